// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared types and constants for the ROM controller KMAC packer
package rom_ctrl_pkg;
  typedef enum logic [5:0] {
    WaitLo = 6'b000111,
    WaitHi = 6'b111000,
    Send   = 6'b011011,
    Done   = 6'b101101,
    Error  = 6'b110110
  } packer_state_e;
  localparam logic [7:0] KmacStrbHalf = 8'h0F;
  localparam logic [7:0] KmacStrbFull = 8'hFF;
endpackage

// File: rtl/rom_ctrl_kmac_packer.sv
// rom_ctrl_kmac_packer: packs 32-bit ROM words into 64-bit KMAC beats with length and protocol checking
module rom_ctrl_kmac_packer
  import rom_ctrl_pkg::*;
#(
  parameter int MaxWords = 16,
  localparam int CntW = $clog2(MaxWords + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rom_vld_i,
  output logic            rom_rdy_o,
  input  logic            rom_last_i,
  input  logic [31:0]     rom_data_i,
  output logic            kmac_valid_o,
  output logic [63:0]     kmac_data_o,
  output logic [7:0]      kmac_strb_o,
  output logic            kmac_last_o,
  input  logic            kmac_ready_i,
  output logic [CntW-1:0] words_o,
  output logic            done_o,
  output logic            alert_o
);
  packer_state_e   state;
  logic [31:0]     hold;
  logic [CntW-1:0] words, words_nxt;
  logic            rom_hs, overflow;
  assign rom_rdy_o    = ~rst_i & (state == WaitLo || state == WaitHi);
  assign rom_hs       = rom_vld_i & rom_rdy_o;
  assign words_nxt    = words + CntW'(1);
  // accepting word number MaxWords without last would exceed the message limit
  assign overflow     = rom_hs & ~rom_last_i & (words_nxt == CntW'(MaxWords));
  assign kmac_valid_o = state == Send;
  assign done_o       = state == Done;
  assign alert_o      = state == Error;
  assign words_o      = words;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= WaitLo;
      hold        <= '0;
      words       <= '0;
      kmac_data_o <= '0;
      kmac_strb_o <= '0;
      kmac_last_o <= 1'b0;
    end else if (rom_hs) begin
      words <= words_nxt;
      if (overflow) begin
        state <= Error;
      end else if (state == WaitLo) begin
        hold <= rom_data_i;
        if (rom_last_i) begin
          kmac_data_o <= {32'h0, rom_data_i};
          kmac_strb_o <= KmacStrbHalf;
          kmac_last_o <= 1'b1;
          state       <= Send;
        end else begin
          state <= WaitHi;
        end
      end else begin
        kmac_data_o <= {rom_data_i, hold};
        kmac_strb_o <= KmacStrbFull;
        kmac_last_o <= rom_last_i;
        state       <= Send;
      end
    end else begin
      case (state)
        Send:                  if (kmac_ready_i) state <= kmac_last_o ? Done : WaitLo;
        Done:                  if (rom_vld_i) state <= Error;
        WaitLo, WaitHi, Error: state <= state;
        default:               state <= Error;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_ctrl_kmac_packer.sv
// tb_rom_ctrl_kmac_packer: randomized self-checking bench against a message-level packing model
module tb_rom_ctrl_kmac_packer;
  localparam int MaxWords = 4;
  localparam int CntW = $clog2(MaxWords + 1);
  logic            clk = 0;
  logic            rst_i = 1;
  logic            rom_vld_i = 0;
  logic            rom_rdy_o;
  logic            rom_last_i = 0;
  logic [31:0]     rom_data_i = '0;
  logic            kmac_valid_o;
  logic [63:0]     kmac_data_o;
  logic [7:0]      kmac_strb_o;
  logic            kmac_last_o;
  logic            kmac_ready_i = 0;
  logic [CntW-1:0] words_o;
  logic            done_o;
  logic            alert_o;
  int checks = 0;
  int errors = 0;
  rom_ctrl_kmac_packer #(.MaxWords(MaxWords)) dut (
    .clk_i(clk), .rst_i(rst_i), .rom_vld_i(rom_vld_i), .rom_rdy_o(rom_rdy_o),
    .rom_last_i(rom_last_i), .rom_data_i(rom_data_i), .kmac_valid_o(kmac_valid_o),
    .kmac_data_o(kmac_data_o), .kmac_strb_o(kmac_strb_o), .kmac_last_o(kmac_last_o),
    .kmac_ready_i(kmac_ready_i), .words_o(words_o), .done_o(done_o), .alert_o(alert_o)
  );
  always #5 clk = ~clk;
  task automatic push_word(input logic [31:0] w, input logic l);
    int n = 0;
    rom_vld_i = 1; rom_data_i = w; rom_last_i = l;
    while (!rom_rdy_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n == 20) begin errors++; $display("FAIL push_timeout rdy=%b want 1", rom_rdy_o); end
    @(negedge clk);
    rom_vld_i = 0; rom_last_i = 0; rom_data_i = $urandom;
  endtask
  task automatic take_beat(input logic [63:0] d, input logic [7:0] s, input logic l, input int stall);
    int n = 0;
    while (!kmac_valid_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n == 20) begin errors++; $display("FAIL beat_timeout valid=%b want 1", kmac_valid_o); end
    checks++;
    if ({kmac_data_o, kmac_strb_o, kmac_last_o} !== {d, s, l}) begin
      errors++;
      $display("FAIL beat got %h/%h/%b want %h/%h/%b", kmac_data_o, kmac_strb_o, kmac_last_o, d, s, l);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if ({kmac_valid_o, rom_rdy_o, kmac_data_o, kmac_strb_o, kmac_last_o} !== {2'b10, d, s, l}) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b r=%b %h want v=1 r=0 %h", i, kmac_valid_o, rom_rdy_o, kmac_data_o, d);
      end
    end
    kmac_ready_i = 1;
    @(negedge clk);
    kmac_ready_i = 0;
    checks++;
    if ({kmac_valid_o, rom_rdy_o, done_o} !== {1'b0, !l, l}) begin
      errors++;
      $display("FAIL after_beat got v=%b r=%b d=%b want v=0 r=%b d=%b", kmac_valid_o, rom_rdy_o, done_o, !l, l);
    end
  endtask
  task automatic do_reset();
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    @(negedge clk);
  endtask
  // drives one message and checks every beat computed from the pairing rule
  task automatic run_msg(input int len, input int max_stall);
    logic [31:0] w [$];
    for (int i = 0; i < len; i++) w.push_back($urandom);
    for (int i = 0; i < len; i++) begin
      push_word(w[i], i == len - 1);
      if (i % 2 == 1) take_beat({w[i], w[i-1]}, 8'hFF, i == len - 1, $urandom_range(0, max_stall));
      else if (i == len - 1) take_beat({32'h0, w[i]}, 8'h0F, 1'b1, $urandom_range(0, max_stall));
    end
    checks++;
    if ({done_o, alert_o, int'(words_o)} !== {2'b10, len}) begin
      errors++;
      $display("FAIL msg_end len %0d got done=%b alert=%b words=%0d", len, done_o, alert_o, words_o);
    end
  endtask
  task automatic test_reset();
    rst_i = 1;
    @(negedge clk);
    checks++;
    if ({rom_rdy_o, kmac_valid_o, kmac_data_o, kmac_strb_o, kmac_last_o, words_o, done_o, alert_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got r=%b v=%b d=%h s=%h w=%0d dn=%b a=%b want all 0", rom_rdy_o, kmac_valid_o, kmac_data_o, kmac_strb_o, words_o, done_o, alert_o);
    end
    rst_i = 0;
    @(negedge clk);
    checks++;
    if (rom_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", rom_rdy_o); end
  endtask
  task automatic test_four_words();
    push_word(32'hA0A0A0A0, 0);
    push_word(32'hA1A1A1A1, 0);
    take_beat(64'hA1A1A1A1_A0A0A0A0, 8'hFF, 0, 0);
    push_word(32'hA2A2A2A2, 0);
    push_word(32'hA3A3A3A3, 1);
    take_beat(64'hA3A3A3A3_A2A2A2A2, 8'hFF, 1, 0);
    checks++;
    if ({done_o, words_o} !== {1'b1, CntW'(4)}) begin
      errors++; $display("FAIL four_done got done=%b words=%0d want 1/4", done_o, words_o);
    end
    do_reset();
  endtask
  task automatic test_odd_last();
    push_word(32'h11111111, 0);
    push_word(32'h22222222, 0);
    take_beat(64'h22222222_11111111, 8'hFF, 0, 0);
    push_word(32'h33333333, 1);
    take_beat(64'h00000000_33333333, 8'h0F, 1, 0);
    checks++;
    if ({done_o, words_o} !== {1'b1, CntW'(3)}) begin
      errors++; $display("FAIL odd_done got done=%b words=%0d want 1/3", done_o, words_o);
    end
    do_reset();
  endtask
  task automatic test_stall();
    push_word(32'hDEADBEEF, 0);
    push_word(32'hCAFEF00D, 0);
    take_beat(64'hCAFEF00D_DEADBEEF, 8'hFF, 0, 5);
    checks++;
    if (words_o !== CntW'(2)) begin errors++; $display("FAIL stall_words got %0d want 2", words_o); end
    do_reset();
  endtask
  task automatic test_overflow();
    push_word(32'h1, 0);
    push_word(32'h2, 0);
    take_beat(64'h2_00000001, 8'hFF, 0, 0);
    push_word(32'h3, 0);
    push_word(32'h4, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({alert_o, kmac_valid_o, rom_rdy_o} !== 3'b100) begin
        errors++; $display("FAIL overflow_err cyc %0d got a=%b v=%b r=%b want 1/0/0", i, alert_o, kmac_valid_o, rom_rdy_o);
      end
      @(negedge clk);
    end
    do_reset();
  endtask
  task automatic test_done_vld();
    push_word(32'h55, 1);
    take_beat(64'h55, 8'h0F, 1, 0);
    rom_vld_i = 1;
    @(negedge clk);
    rom_vld_i = 0;
    checks++;
    if (alert_o !== 1'b1) begin errors++; $display("FAIL done_vld_alert got %b want 1", alert_o); end
    rst_i = 1;
    @(negedge clk);
    checks++;
    if ({rom_rdy_o, kmac_valid_o, kmac_data_o, kmac_strb_o, kmac_last_o, words_o, done_o, alert_o} !== '0) begin
      errors++; $display("FAIL done_vld_reset got a=%b dn=%b w=%0d d=%h want all 0", alert_o, done_o, words_o, kmac_data_o);
    end
    rst_i = 0;
    @(negedge clk);
    run_msg(2, 0);
    do_reset();
  endtask
  task automatic test_reset_in_send();
    push_word(32'h77, 0);
    push_word(32'h88, 0);
    checks++;
    if (kmac_valid_o !== 1'b1) begin errors++; $display("FAIL rst_send_valid got %b want 1", kmac_valid_o); end
    rst_i = 1;
    @(negedge clk);
    checks++;
    if ({kmac_valid_o, words_o} !== '0) begin
      errors++; $display("FAIL rst_send_clear got v=%b w=%0d want 0/0", kmac_valid_o, words_o);
    end
    rst_i = 0;
    @(negedge clk);
    checks++;
    if (rom_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_send_rdy got %b want 1", rom_rdy_o); end
  endtask
  task automatic test_random();
    for (int m = 0; m < 12; m++) begin
      run_msg($urandom_range(1, MaxWords), 3);
      do_reset();
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_four_words();
    test_odd_last();
    test_stall();
    test_overflow();
    test_done_vld();
    test_reset_in_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_ctrl_kmac_packer.md
Name: rom_ctrl_kmac_packer

Overview:
- Sits between the ROM checker FSM's ROM-data stream (32-bit words, valid/ready/last) and the KMAC application interface (64-bit beats with byte strobe).
- Packs two consecutive ROM words into one KMAC beat. Handles an odd final word with a half strobe.
- Counts accepted words and enforces a maximum message length.
- Any protocol violation drives the block into a terminal Error state with a sticky alert.

Parameters:
- MaxWords, 16, maximum number of ROM words in one message, including the last; must be >= 1.
- CntW, vbits(MaxWords+1), width of the word counter (derived; not overridden).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- rom_vld_i  in  1  ROM word valid
- rom_rdy_o  out  1  ROM word ready
- rom_last_i  in  1  current word is the last of the message (sampled only on handshake)
- rom_data_i  in  32  ROM word
- kmac_valid_o  out  1  KMAC beat valid
- kmac_data_o  out  64  beat data; low word in [31:0]
- kmac_strb_o  out  8  byte strobe
- kmac_last_o  out  1  final beat of message
- kmac_ready_i  in  1  KMAC accepts beat
- words_o  out  CntW  number of ROM words accepted so far
- done_o  out  1  high in state Done
- alert_o  out  1  high in state Error (sticky)

Interface note:
- One clock; reset is synchronous and active-high. Clock is clk_i, reset is rst_i.
- All state updates on posedge clk_i. rst_i is sampled at the clock edge.

Behaviour:
- Reset values (also applied on rst_i mid-operation, whatever the state): state WaitLo, holding reg 0, words_o 0, kmac_valid_o 0, kmac_data_o 0, kmac_strb_o 0, kmac_last_o 0, done_o 0, alert_o 0, rom_rdy_o 0 during the reset cycle. A beat in flight is dropped.
- Handshakes:
  - ROM handshake: rom_vld_i & rom_rdy_o.
  - KMAC handshake: kmac_valid_o & kmac_ready_i.
  - kmac_data_o, kmac_strb_o and kmac_last_o are registered and stable while kmac_valid_o=1 and kmac_ready_i=0.
- rom_rdy_o = 1 only in WaitLo and WaitHi (combinational from state only). There is no overlap with Send, so peak throughput is 2 words per 3 cycles.
- States (sparse encoding, Hamming distance >= 3):
  - WaitLo: on handshake, store word in reg[31:0] and increment words.
    - rom_last_i=1: load output {32'h0, word}, strb 8'h0F, last 1; go Send.
    - otherwise go WaitHi.
  - WaitHi: on handshake, load output {word, reg[31:0]}, strb 8'hFF, last=rom_last_i; increment words; go Send.
  - Send: kmac_valid_o=1. On KMAC handshake, go Done if last, else WaitLo. Output clears kmac_valid_o next cycle.
  - Done: terminal. done_o=1. rom_rdy_o=0.
  - Error: terminal. alert_o=1. All other outputs hold their values except kmac_valid_o, which is 0. Only rst_i leaves this state.
- Error entry (takes priority over the normal transition, applied the next cycle):
  - A handshake that would make words exceed MaxWords without rom_last_i=1. Concretely, accepting word number MaxWords with last=0.
  - rom_vld_i=1 while in Done.
  - Any unencoded state value.
- words_o saturates naturally because the overflow goes to Error. It never wraps.
- rom_last_i is ignored when there is no handshake.
- Simultaneous rom_vld_i in Send: not accepted (rom_rdy_o=0). It is not an error; the upstream holds the word.
- MaxWords=1: only a single low-half beat with strb 8'h0F is possible.

Decomposition:
- rom_ctrl_pkg gains:
  - packer_state_e: 6-bit sparse enum with values WaitLo, WaitHi, Send, Done, Error.
  - Constants: KmacStrbHalf = 8'h0F and KmacStrbFull = 8'hFF.
- No sub-module. The state register uses the sparse-FSM flop primitive with reset value WaitLo.
- The output beat register and the word counter are local.

Test Plan:
- 4 words A0..A3, last on A3, kmac_ready_i=1 -> two beats:
  - {A1,A0}, strb FF, last 0.
  - {A3,A2}, strb FF, last 1.
  - Then done_o=1 and words_o=4.
- 3 words with last on the 3rd (0x33333333) -> second beat is {0x00000000,0x33333333}, strb 0F, last 1, then Done.
- kmac_ready_i held 0 for 5 cycles in Send -> kmac_data_o stable and rom_rdy_o=0 throughout. Release -> beat accepted in one cycle, state WaitLo.
- MaxWords=4, 4 words with last never set -> alert_o=1 the cycle after the 4th handshake, kmac_valid_o=0, and the state stays Error for 10 cycles.
- After Done, rom_vld_i=1 -> alert_o=1 next cycle. Then rst_i=1 for 1 cycle -> all outputs 0 and a new 2-word message packs correctly.
- rst_i asserted while in Send with kmac_ready_i=0 -> next cycle kmac_valid_o=0, words_o=0, rom_rdy_o=1 once rst_i deasserts.
